// File: rtl/calc_sequencer_if.sv
// Bundle of the command-entry, ALU and status signals of calc_sequencer.
//   NumIn/OpIn/Enter    : command operand, opcode and push strobe (level, edge-detected)
//   Go/Clear            : start draining / synchronous flush
//   AluOp/AluA/AluB     : operands driven to the shared external ALU
//   AluResult           : combinational result returned by that ALU
//   NumOut              : accumulator value
//   Busy/Full/Empty     : sequencer and queue status
//   Overflow            : sticky flag, a push was dropped
// Modport slave is the sequencer side, master is the environment side.
interface calc_sequencer_if;
    logic [7:0] NumIn;
    logic [1:0] OpIn;
    logic       Enter;
    logic       Go;
    logic       Clear;
    logic [1:0] AluOp;
    logic [7:0] AluA;
    logic [7:0] AluB;
    logic [7:0] AluResult;
    logic [7:0] NumOut;
    logic       Busy;
    logic       Full;
    logic       Empty;
    logic       Overflow;

    modport slave (
        input  NumIn, OpIn, Enter, Go, Clear, AluResult,
        output AluOp, AluA, AluB, NumOut, Busy, Full, Empty, Overflow
    );

    modport master (
        output NumIn, OpIn, Enter, Go, Clear, AluResult,
        input  AluOp, AluA, AluB, NumOut, Busy, Full, Empty, Overflow
    );
endinterface

// File: rtl/calc_sequencer.sv
// Command sequencer: queues {opcode, operand} commands and, on Go, feeds them
// one at a time to an external combinational ALU, writing the result back into
// an 8-bit accumulator. One command completes every two cycles (ISSUE, WB).
//   clock : sole clock, rising edge
//   Reset : asynchronous, active-low
//   bus   : calc_sequencer_if.slave (command entry, ALU operands/result, status)
module calc_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic              clock,
    input  logic              Reset,
    calc_sequencer_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

    state_t             state_reg, state_next;
    logic [9:0]         mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [7:0]         acc_reg;
    logic               enter_reg;
    logic               overflow_reg;
    logic               push_req, pop, push_ok;
    logic [9:0]         head;

    assign head     = mem[rd_ptr_reg];
    assign push_req = bus.Enter & ~enter_reg;
    assign pop      = (state_reg == WB);
    // A full queue still takes a push when the head is popped on the same edge.
    assign push_ok  = push_req && ((count_reg != CNT_W'(DEPTH)) || pop);

    always_comb begin
        count_next = count_reg - CNT_W'(pop) + CNT_W'(push_ok);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.Go && (count_reg != '0)) state_next = ISSUE;
            ISSUE:   state_next = WB;
            // Occupancy after this edge decides, so commands pushed while
            // draining join the current run.
            WB:      state_next = (count_next != '0) ? ISSUE : IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.Clear) state_next = IDLE;
    end

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state_reg    <= IDLE;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            acc_reg      <= '0;
            enter_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            enter_reg <= bus.Enter;
            state_reg <= state_next;
            if (bus.Clear) begin
                rd_ptr_reg   <= '0;
                wr_ptr_reg   <= '0;
                count_reg    <= '0;
                acc_reg      <= '0;
                overflow_reg <= 1'b0;
            end else begin
                if (push_ok) wr_ptr_reg <= PTR_W'(wr_ptr_reg + 1'b1);
                if (pop) begin
                    rd_ptr_reg <= PTR_W'(rd_ptr_reg + 1'b1);
                    acc_reg    <= bus.AluResult;
                end
                count_reg <= count_next;
                if (push_req && !push_ok) overflow_reg <= 1'b1;
            end
        end
    end

    // Queue storage carries no reset; entries are only visible through the
    // head while the FSM is busy, and the pointers are reset.
    always_ff @(posedge clock) begin
        if (Reset && !bus.Clear && push_ok) begin
            mem[wr_ptr_reg] <= {bus.OpIn, bus.NumIn};
        end
    end

    assign bus.AluOp    = (state_reg == IDLE) ? 2'b00 : head[9:8];
    assign bus.AluB     = (state_reg == IDLE) ? 8'h00 : head[7:0];
    assign bus.AluA     = acc_reg;
    assign bus.NumOut   = acc_reg;
    assign bus.Busy     = (state_reg != IDLE);
    assign bus.Full     = (count_reg == CNT_W'(DEPTH));
    assign bus.Empty    = (count_reg == '0);
    assign bus.Overflow = overflow_reg;
endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic Reset = 1'b0;

    calc_sequencer_if bus();

    calc_sequencer #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Behavioural ALU: 00 add, 01 sub, 10 or, 11 equal-test (1 when equal).
    function automatic logic [7:0] alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a | b;
            default: return (a == b) ? 8'h01 : 8'h00;
        endcase
    endfunction

    assign bus.AluResult = alu(bus.AluOp, bus.AluA, bus.AluB);

    int tests  = 0;
    int failed = 0;

    // Reference model: pending commands, accumulator, sticky overflow.
    logic [9:0] model_q[$];
    logic [9:0] extra_q[$];
    logic [7:0] model_acc = 8'h00;
    logic       model_ovf = 1'b0;
    bit         always_push = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear;
        model_q.delete();
        model_acc = 8'h00;
        model_ovf = 1'b0;
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [7:0] num);
        bus.OpIn  = op;
        bus.NumIn = num;
        bus.Enter = 1'b1;
        step;
        if (model_q.size() < DEPTH) model_q.push_back({op, num});
        else model_ovf = 1'b1;
        chk("push_full",  bus.Full,     model_q.size() == DEPTH);
        chk("push_empty", bus.Empty,    model_q.size() == 0);
        chk("push_ovf",   bus.Overflow, model_ovf);
        $display("[TB] push op=%0d num=%02h count=%0d ovf=%0d", op, num, model_q.size(), model_ovf);
        bus.Enter = 1'b0;
        step;
    endtask

    // Start a run with Go and follow it until the model queue is empty,
    // optionally pushing commands from extra_q on WB edges.
    task automatic drain;
        logic [9:0] h;
        logic [9:0] pend;
        bit pushed;
        bus.Go = 1'b1;
        step;
        bus.Go = 1'b0;
        for (int it = 0; it < 64; it++) begin
            h = model_q[0];
            chk("busy_issue",  bus.Busy,  1);
            chk("aluop_issue", bus.AluOp, h[9:8]);
            chk("alub_issue",  bus.AluB,  h[7:0]);
            chk("alua_issue",  bus.AluA,  model_acc);
            step;
            chk("busy_wb",  bus.Busy,  1);
            chk("aluop_wb", bus.AluOp, h[9:8]);
            chk("alub_wb",  bus.AluB,  h[7:0]);
            pushed = 1'b0;
            pend   = '0;
            if (extra_q.size() > 0 && (always_push || $urandom_range(0, 1) == 1)) begin
                pend = extra_q.pop_front();
                {bus.OpIn, bus.NumIn} = pend;
                bus.Enter = 1'b1;
                pushed = 1'b1;
            end
            step;
            model_acc = alu(h[9:8], model_acc, h[7:0]);
            void'(model_q.pop_front());
            if (pushed) model_q.push_back(pend);
            $display("[TB] wb op=%0d b=%02h numout=%02h exp=%02h push=%0d", h[9:8], h[7:0], bus.NumOut, model_acc, pushed);
            chk("numout_wb", bus.NumOut,   model_acc);
            chk("full_wb",   bus.Full,     model_q.size() == DEPTH);
            chk("ovf_wb",    bus.Overflow, model_ovf);
            bus.Enter = 1'b0;
            if (model_q.size() == 0) begin
                chk("busy_done",  bus.Busy,  0);
                chk("empty_done", bus.Empty, 1);
                break;
            end
        end
        extra_q.delete();
        step;
    endtask

    task automatic do_clear;
        bus.Clear = 1'b1;
        step;
        bus.Clear = 1'b0;
        model_clear();
        chk("clr_numout", bus.NumOut,   0);
        chk("clr_empty",  bus.Empty,    1);
        chk("clr_ovf",    bus.Overflow, 0);
        chk("clr_busy",   bus.Busy,     0);
        $display("[TB] clear");
    endtask

    initial begin
        bus.NumIn = '0;
        bus.OpIn  = '0;
        bus.Enter = 1'b0;
        bus.Go    = 1'b0;
        bus.Clear = 1'b0;

        // Outputs while held in reset
        #2;
        chk("rst_numout", bus.NumOut,   0);
        chk("rst_aluop",  bus.AluOp,    0);
        chk("rst_alua",   bus.AluA,     0);
        chk("rst_alub",   bus.AluB,     0);
        chk("rst_busy",   bus.Busy,     0);
        chk("rst_full",   bus.Full,     0);
        chk("rst_empty",  bus.Empty,    1);
        chk("rst_ovf",    bus.Overflow, 0);
        $display("[TB] reset state checked");
        #20 Reset = 1'b1;
        model_clear();
        step;

        // Basic run: 5, 12, 9
        push_cmd(2'b00, 8'd5);
        push_cmd(2'b00, 8'd7);
        push_cmd(2'b01, 8'd3);
        drain();
        chk("basic_result", bus.NumOut, 8'd9);

        // Five pushes into a four-entry queue
        do_clear();
        for (int i = 0; i < 5; i++) push_cmd(2'(i), 8'(8'h10 + i));
        chk("ovf_full", bus.Full, 1);
        drain();
        chk("ovf_sticky", bus.Overflow, 1);
        do_clear();

        // Push accepted on the same edge as a WB pop of a full queue
        for (int i = 0; i < 4; i++) push_cmd(2'b00, 8'(i + 1));
        extra_q.push_back({2'b00, 8'h40});
        always_push = 1'b1;
        drain();
        always_push = 1'b0;
        chk("fullpop_ovf", bus.Overflow, 0);

        // Enter held high for 10 cycles gives one push
        bus.OpIn  = 2'b10;
        bus.NumIn = 8'h81;
        bus.Enter = 1'b1;
        for (int i = 0; i < 10; i++) step;
        model_q.push_back({2'b10, 8'h81});
        bus.Enter = 1'b0;
        step;
        chk("hold_empty", bus.Empty, 0);
        drain();

        // Clear during ISSUE of the second of three commands
        do_clear();
        push_cmd(2'b00, 8'd3);
        push_cmd(2'b00, 8'd4);
        push_cmd(2'b00, 8'd5);
        bus.Go = 1'b1;
        step;
        bus.Go = 1'b0;
        step;
        step;
        chk("clr_mid_busy_pre", bus.Busy, 1);
        bus.Clear = 1'b1;
        step;
        bus.Clear = 1'b0;
        model_clear();
        chk("clr_mid_busy",   bus.Busy,   0);
        chk("clr_mid_numout", bus.NumOut, 0);
        chk("clr_mid_empty",  bus.Empty,  1);
        for (int i = 0; i < 3; i++) begin
            step;
            chk("clr_mid_idle", bus.Busy,   0);
            chk("clr_mid_hold", bus.NumOut, 0);
        end
        $display("[TB] clear mid-run checked");

        // Reset asserted in WB with accumulator 0x20
        push_cmd(2'b00, 8'h20);
        drain();
        chk("pre_rst_acc", bus.NumOut, 8'h20);
        push_cmd(2'b00, 8'h01);
        push_cmd(2'b00, 8'h02);
        bus.Go = 1'b1;
        step;
        bus.Go = 1'b0;
        step;
        #2 Reset = 1'b0;
        #1;
        chk("arst_numout", bus.NumOut, 0);
        chk("arst_empty",  bus.Empty,  1);
        chk("arst_busy",   bus.Busy,   0);
        chk("arst_aluop",  bus.AluOp,  0);
        #3 Reset = 1'b1;
        model_clear();
        step;
        bus.Go = 1'b1;
        step;
        chk("arst_go_ignored", bus.Busy, 0);
        step;
        chk("arst_go_ignored2", bus.Busy, 0);
        bus.Go = 1'b0;
        $display("[TB] async reset mid-run checked");
        push_cmd(2'b01, 8'h05);
        drain();

        // Randomized runs with pushes during draining
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) push_cmd(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            for (int i = 0; i < int'($urandom_range(0, 3)); i++)
                extra_q.push_back(10'($urandom_range(0, 1023)));
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
